ram_half_arbiter: RTL and testbench

- Shares the single 32Mx16 RAM controller port between two requesters: the SD-card loader (writes) and the media playback reader (reads).
- Schedules ping-pong use of the two RAM halves. The loader fills one half while playback drains the other.
- Drives the loader's half-authorisation input (ram_init_half) and tells playback which half is valid.
- Sits between the SD loader, the playback engine and the RAM controller.

---
 rtl/ram_half_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_half_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_half_arbiter.sv
// Ping-pong RAM half arbiter: shares one RAM controller port between the SD
// loader (writes) and the playback reader (reads). The loader fills one half
// while playback drains the other; full[] tracks which halves hold data.
module ram_half_arbiter #(
  parameter int                ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] HALF_BASE = 25'h0800000,
  parameter int                OFFS_W    = 23
) (
  input  logic              clk50,
  input  logic              reset_n,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_address,
  input  logic [15:0]       ld_data,
  output logic              ld_op_begun,
  input  logic              ld_half_done,
  output logic              ld_half,
  input  logic              pb_re,
  input  logic [OFFS_W-1:0] pb_offset,
  output logic [15:0]       pb_data,
  output logic              pb_valid,
  input  logic              pb_half_done,
  output logic              pb_half,
  output logic              pb_ready,
  output logic              underrun,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_address,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  input  logic              ram_op_begun,
  input  logic              ram_rdata_valid
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;
  typedef enum logic {GNT_WR, GNT_RD} grant_t;

  state_t            state;
  grant_t            last_grant;
  logic [1:0]        full;
  logic [1:0]        full_nx;
  logic              ld_done_q;
  logic              ld_rise;
  logic              pb_clear;
  logic              ld_flip;
  logic              ld_ok;
  logic              pb_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_target;

  assign pb_ready  = full[pb_half];
  assign ld_ok     = ld_we & (ld_address[OFFS_W] == ld_half) & ~full[ld_half];
  // pb_re is still high in the cycle pb_valid pulses; masking it there keeps a
  // completed read from being granted a second time.
  assign pb_ok     = pb_re & pb_ready & ~pb_valid;
  assign ld_rise   = ld_half_done & ~ld_done_q;
  assign pb_clear  = pb_half_done & pb_ready;
  assign rd_target = ADDR_W'(pb_offset) + (pb_half ? HALF_BASE : '0);

  // Next fill state: set for the loader's half, then clear for playback's half
  // so a same-bit collision resolves as a clear.
  always_comb begin
    full_nx = full;
    if (ld_rise)  full_nx[ld_half] = 1'b1;
    if (pb_clear) full_nx[pb_half] = 1'b0;
  end

  // The loader moves on as soon as its half is full and the other one is free,
  // covering both the immediate toggle and the deferred flip after playback frees it.
  assign ld_flip = full_nx[ld_half] & ~full_nx[~ld_half];

  // Half ownership, fill flags and sticky underrun.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      full      <= '0;
      ld_half   <= 1'b0;
      pb_half   <= 1'b0;
      ld_done_q <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      full      <= full_nx;
      ld_done_q <= ld_half_done;
      if (ld_flip)              ld_half  <= ~ld_half;
      if (pb_clear)             pb_half  <= ~pb_half;
      if (pb_re && !pb_ready)   underrun <= 1'b1;
    end
  end

  // Arbiter FSM: one RAM operation at a time, alternating on contention.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GNT_WR;
      rd_addr    <= '0;
      pb_data    <= '0;
      pb_valid   <= 1'b0;
    end else begin
      pb_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pb_ok && (!ld_ok || last_grant == GNT_WR)) begin
            state      <= RD;
            last_grant <= GNT_RD;
            rd_addr    <= rd_target;
          end else if (ld_ok) begin
            state      <= WR;
            last_grant <= GNT_WR;
          end
        end
        WR: begin
          if (ram_op_begun) state <= IDLE;
        end
        RD: begin
          if (ram_op_begun) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (ram_rdata_valid) begin
            pb_data  <= ram_rdata;
            pb_valid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port drive decoded from the state register; the loader ack follows
  // ram_op_begun in the same cycle.
  always_comb begin
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_address = '0;
    ram_wdata   = '0;
    ld_op_begun = 1'b0;
    unique case (state)
      WR: begin
        ram_we      = 1'b1;
        ram_address = ld_address;
        ram_wdata   = ld_data;
        ld_op_begun = ram_op_begun;
      end
      RD: begin
        ram_re      = 1'b1;
        ram_address = rd_addr;
      end
      RD_WAIT: ram_address = rd_addr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_half_arbiter.sv
// Self-checking bench for ram_half_arbiter: vector table, hand sequences for
// arbitration/half hand-over/reset, and a randomized phase against a model.
`timescale 1ns/1ps
module tb_ram_half_arbiter;

  localparam logic [24:0] HALF_BASE = 25'h0800000;
  // Read data returned by the RAM stand-in is address[15:0] ^ RD_KEY;
  // offset 5 in the upper half therefore reads back 0x1234.
  localparam logic [15:0] RD_KEY = 16'h1231;

  logic        clk50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_we = 1'b0;
  logic [24:0] ld_address = '0;
  logic [15:0] ld_data = '0;
  logic        ld_op_begun;
  logic        ld_half_done = 1'b0;
  logic        ld_half;
  logic        pb_re = 1'b0;
  logic [22:0] pb_offset = '0;
  logic [15:0] pb_data;
  logic        pb_valid;
  logic        pb_half_done = 1'b0;
  logic        pb_half;
  logic        pb_ready;
  logic        underrun;
  logic        ram_we;
  logic        ram_re;
  logic [24:0] ram_address;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic        ram_op_begun = 1'b0;
  logic        ram_rdata_valid = 1'b0;

  always #10 clk50 = ~clk50;

  ram_half_arbiter #(.ADDR_W(25), .HALF_BASE(25'h0800000), .OFFS_W(23)) dut (
    .clk50(clk50), .reset_n(reset_n),
    .ld_we(ld_we), .ld_address(ld_address), .ld_data(ld_data),
    .ld_op_begun(ld_op_begun), .ld_half_done(ld_half_done), .ld_half(ld_half),
    .pb_re(pb_re), .pb_offset(pb_offset), .pb_data(pb_data), .pb_valid(pb_valid),
    .pb_half_done(pb_half_done), .pb_half(pb_half), .pb_ready(pb_ready),
    .underrun(underrun),
    .ram_we(ram_we), .ram_re(ram_re), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_op_begun(ram_op_begun), .ram_rdata_valid(ram_rdata_valid)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  // Reference model of half ownership, written from the hand-over rules.
  bit [1:0] m_full;
  bit       m_ld, m_pb, m_under, m_done_prev, m_wait, m_rdy;
  always @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      m_full = '0; m_ld = 0; m_pb = 0; m_under = 0; m_done_prev = 0; m_wait = 0;
    end else begin
      m_rdy = m_full[m_pb];
      if (pb_re && !m_rdy) m_under = 1;
      if (ld_half_done && !m_done_prev) begin
        m_full[m_ld] = 1;
        m_wait = 1;
      end
      m_done_prev = ld_half_done;
      if (pb_half_done && m_rdy) begin
        m_full[m_pb] = 0;
        m_pb = !m_pb;
      end
      if (m_wait && !m_full[!m_ld]) begin
        m_ld = !m_ld;
        m_wait = 0;
      end
    end
  end

  // RAM controller stand-in: accepts after ram_delay cycles, read data one cycle later.
  int unsigned ram_delay = 0;
  int unsigned wcnt = 0;
  bit          rd_hold = 0;
  bit          rd_pend = 0;
  logic [15:0] rd_val = '0;
  always @(negedge clk50) begin
    ram_op_begun = 1'b0;
    ram_rdata_valid = 1'b0;
    if (!reset_n) begin
      rd_pend = 0;
      wcnt = 0;
    end else if (rd_pend) begin
      if (!rd_hold) begin
        ram_rdata_valid = 1'b1;
        ram_rdata = rd_val;
        rd_pend = 0;
      end
    end else if (ram_we || ram_re) begin
      if (wcnt >= ram_delay) begin
        ram_op_begun = 1'b1;
        wcnt = 0;
        if (ram_re) begin
          rd_pend = 1;
          rd_val = ram_address[15:0] ^ RD_KEY;
        end
      end else begin
        wcnt++;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk50);
    #1;
  endtask

  task automatic check_model();
    chk("ld_half", 32'(ld_half), 32'(m_ld));
    chk("pb_half", 32'(pb_half), 32'(m_pb));
    chk("pb_ready", 32'(pb_ready), 32'(m_full[m_pb]));
    chk("underrun", 32'(underrun), 32'(m_under));
  endtask

  task automatic check_reset_outputs();
    chk("rst_ld_op_begun", 32'(ld_op_begun), 0);
    chk("rst_ld_half", 32'(ld_half), 0);
    chk("rst_pb_data", 32'(pb_data), 0);
    chk("rst_pb_valid", 32'(pb_valid), 0);
    chk("rst_pb_half", 32'(pb_half), 0);
    chk("rst_pb_ready", 32'(pb_ready), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_re", 32'(ram_re), 0);
    chk("rst_ram_address", 32'(ram_address), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
  endtask

  task automatic apply_reset();
    ld_we = 0; pb_re = 0; ld_half_done = 0; pb_half_done = 0; rd_hold = 0;
    reset_n = 0;
    step();
    step();
    reset_n = 1;
    step();
  endtask

  task automatic pulse_ld_done();
    ld_half_done = 1;
    step();
    ld_half_done = 0;
    step();
  endtask

  task automatic pulse_pb_done();
    pb_half_done = 1;
    step();
    pb_half_done = 0;
  endtask

  task automatic do_write(input logic [24:0] addr, input logic [15:0] data,
                          input int unsigned dly, input bit exp_ack);
    int we_cyc;
    int ack_cyc;
    we_cyc = -1;
    ack_cyc = -1;
    ram_delay = dly;
    ld_we = 1; ld_address = addr; ld_data = data;
    for (int i = 0; i < 12 && ack_cyc < 0; i++) begin
      step();
      if (ram_we && we_cyc < 0) begin
        we_cyc = i;
        chk("wr_addr", 32'(ram_address), 32'(addr));
        chk("wr_data", 32'(ram_wdata), 32'(data));
      end
      if (ld_op_begun) begin
        ack_cyc = i;
        ld_we = 0;
      end
    end
    ld_we = 0;
    if (exp_ack) begin
      chk("wr_granted", 32'(we_cyc >= 0), 1);
      chk("wr_ack_latency", 32'(ack_cyc - we_cyc), 32'(dly));
      step();
      chk("wr_ack_pulse", 32'(ld_op_begun), 0);
      chk("wr_strobe_off", 32'(ram_we), 0);
    end else begin
      chk("wr_stall_we", 32'(we_cyc >= 0), 0);
      chk("wr_stall_ack", 32'(ack_cyc >= 0), 0);
    end
  endtask

  task automatic do_read(input logic [22:0] offs, input int unsigned dly,
                         input bit exp_grant, input logic [24:0] exp_addr);
    int re_cyc;
    int v_cyc;
    logic [15:0] exp_data;
    re_cyc = -1;
    v_cyc = -1;
    exp_data = exp_addr[15:0] ^ RD_KEY;
    ram_delay = dly;
    pb_re = 1; pb_offset = offs;
    for (int i = 0; i < 14 && v_cyc < 0; i++) begin
      step();
      if (ram_re && re_cyc < 0) begin
        re_cyc = i;
        chk("rd_addr", 32'(ram_address), 32'(exp_addr));
      end
      if (re_cyc >= 0 && !ram_re && !pb_valid)
        chk("rd_hold_addr", 32'(ram_address), 32'(exp_addr));
      if (pb_valid) begin
        v_cyc = i;
        pb_re = 0;
        chk("rd_data", 32'(pb_data), 32'(exp_data));
      end
    end
    pb_re = 0;
    if (exp_grant) begin
      chk("rd_completed", 32'(v_cyc >= 0), 1);
      step();
      chk("rd_valid_pulse", 32'(pb_valid), 0);
    end else begin
      chk("rd_stall_re", 32'(re_cyc >= 0), 0);
      chk("rd_stall_valid", 32'(v_cyc >= 0), 0);
    end
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [15:0] data;
    int unsigned dly;
    bit          done_before;
    bit          exp_ack;
    bit          exp_ld;
    bit          exp_ready;
  } wr_vec_t;

  wr_vec_t     vecs[6];
  int          grants[6];
  int          ng;
  bit          prev_we, prev_re, seen_re, in_wait;
  bit          half;
  logic [22:0] offs;
  logic [24:0] a;

  initial begin
    vecs[0] = '{25'h0000010, 16'hBEEF, 3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{25'h0000020, 16'h1111, 1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{25'h0800020, 16'h2222, 0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{25'h0800021, 16'h3333, 2, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{25'h0000022, 16'h4444, 1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{25'h0800023, 16'h5555, 1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Outputs stay at reset values while reset is held, even with requests up.
    reset_n = 0;
    ld_we = 1; ld_address = 25'h0000010; pb_re = 1;
    step();
    step();
    check_reset_outputs();
    apply_reset();

    // Vector table: writes, authorisation and full-half stalls.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].done_before) pulse_ld_done();
      do_write(vecs[i].addr, vecs[i].data, vecs[i].dly, vecs[i].exp_ack);
      chk("vec_ld_half", 32'(ld_half), 32'(vecs[i].exp_ld));
      chk("vec_pb_ready", 32'(pb_ready), 32'(vecs[i].exp_ready));
      check_model();
    end

    // Both halves full: loader stays put until playback frees its half.
    ld_half_done = 1;
    step(); step(); step();
    chk("both_full_ld_half", 32'(ld_half), 1);
    pulse_pb_done();
    step();
    chk("handover_pb_half", 32'(pb_half), 1);
    chk("handover_ld_half", 32'(ld_half), 0);
    chk("handover_pb_ready", 32'(pb_ready), 1);
    ld_half_done = 0;
    step();
    check_model();

    // Read from the upper half.
    do_read(23'h000005, 1, 1'b1, 25'h0800005);
    chk("rd_data_1234", 32'(pb_data), 32'h1234);
    check_model();

    // Contention: grants alternate starting with a read.
    apply_reset();
    pulse_ld_done();
    ram_delay = 0;
    ld_we = 1; ld_address = 25'h0800040; ld_data = 16'hCAFE;
    pb_re = 1; pb_offset = 23'h000007;
    for (int i = 0; i < 6; i++) grants[i] = -1;
    ng = 0; prev_we = 0; prev_re = 0;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      step();
      if (ram_re && !prev_re) begin grants[ng] = 1; ng++; end
      else if (ram_we && !prev_we) begin grants[ng] = 0; ng++; end
      prev_re = ram_re;
      prev_we = ram_we;
    end
    ld_we = 0; pb_re = 0;
    for (int i = 0; i < 6; i++)
      chk("alt_grant_is_read", 32'(grants[i]), 32'((i % 2) == 0 ? 1 : 0));
    for (int i = 0; i < 6; i++) step();
    check_model();

    // Randomized traffic checked against the model.
    apply_reset();
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          half = 1'($urandom_range(0, 1));
          a = {1'b0, half, 23'($urandom)};
          do_write(a, 16'($urandom), $urandom_range(0, 3), (half == m_ld) && !m_full[m_ld]);
        end
        2, 3: begin
          offs = 23'($urandom);
          a = {2'b00, offs} + (m_pb ? HALF_BASE : 25'h0);
          do_read(offs, $urandom_range(0, 3), m_full[m_pb], a);
        end
        4: pulse_ld_done();
        default: begin
          pulse_pb_done();
          step();
        end
      endcase
      check_model();
    end

    // Underrun is sticky; reset during RD_WAIT clears everything.
    apply_reset();
    do_read(23'h000003, 0, 1'b0, 25'h0000003);
    chk("underrun_set", 32'(underrun), 1);
    step(); step(); step();
    chk("underrun_sticky", 32'(underrun), 1);
    pulse_ld_done();
    rd_hold = 1;
    ram_delay = 0;
    pb_re = 1; pb_offset = 23'h000009;
    seen_re = 0; in_wait = 0;
    for (int i = 0; i < 10 && !in_wait; i++) begin
      step();
      if (ram_re) seen_re = 1;
      else if (seen_re) in_wait = 1;
    end
    chk("rdwait_reached", 32'(in_wait), 1);
    chk("rdwait_addr", 32'(ram_address), 32'h0000009);
    #1;
    reset_n = 0;
    #1;
    chk("midop_rst_ram_re", 32'(ram_re), 0);
    chk("midop_rst_pb_valid", 32'(pb_valid), 0);
    chk("midop_rst_underrun", 32'(underrun), 0);
    chk("midop_rst_ram_address", 32'(ram_address), 0);
    chk("midop_rst_pb_ready", 32'(pb_ready), 0);
    pb_re = 0;
    rd_hold = 0;
    step();
    reset_n = 1;
    step();
    step();
    chk("post_rst_pb_valid", 32'(pb_valid), 0);
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
